hosted_sys_mem: RTL and testbench
=================================

# hosted_sys_mem

Simulation-side system memory that terminates the `sys_mem` AXI burst master port of the hosted CPU+NPU top. It backs a word array with a single-ported access machine, so reads and writes share one array port under round-robin arbitration. It serves instruction fetch, data and NPU traffic after they are merged by the hosted interconnect. The array is preloadable from a hex file so the hosted simulator can boot firmware and weights.

## Interface
- `DEPTH_WORDS`, 65536: array depth in 32-bit words (256 KiB); power of two.
- `BASE_ADDR`, 32'h0000_0000: byte address mapped to word 0.
- `INIT_FILE`, "": hex file loaded with `$readmemh` at time 0 when non-empty.
- `clk`  in  1  single clock.
- `srst`  in  1  reset, synchronous, active-high.
- `sys_mem`  `axib_if.s`  interface  AXI burst slave. Data is 32-bit with a 4-bit `wstrb`. ID, length and burst fields are as defined by `axib_if`.

## Operation
- States: IDLE, WDATA, WRESP, RDATA.
- IDLE:
  - `awready` = 1 when the write is granted; `arready` = 1 when the read is granted. They are never both 1.
  - If only one of `awvalid`/`arvalid` is high, that request is granted.
  - If both are high, the grant goes to the type opposite the last completed transaction. After reset, write has priority.
- AW handshake: latch `awid`, word address, `awlen` and `awburst`; clear the beat counter; go to WDATA.
- WDATA:
  - `wready` = 1.
  - On each W handshake, write bytes whose `wstrb` bit is set, then advance the address.
  - INCR and WRAP advance the address by one word; WRAP is treated as INCR. FIXED holds the address.
  - When the beat counter equals `awlen`, go to WRESP. `wlast` does not terminate the burst.
- WRESP: `bvalid` = 1 with the latched `bid` and `bresp` = OKAY unless an error applies. On `bready`, go to IDLE.
- AR handshake: latch ID, address, length and burst; issue an array read; go to RDATA.
- RDATA:
  - `rvalid` = 1, and `rdata` comes from the registered array output. `rlast` = 1 on beat `arlen`.
  - On an R handshake, fetch the next word. `rvalid` is held continuously across beats (no bubble).
  - After the last handshake, go to IDLE.
- Address decode: word index = (`addr` − `BASE_ADDR`) >> 2, truncated to log2(`DEPTH_WORDS`) bits. Out-of-range handling depends on the configuration (below).
- Sub-word address bits [1:0] are ignored. Strobes carry byte selection.

## Timing
- Reset values: state IDLE; `bvalid`, `rvalid`, `rlast`, `wready` = 0; `bresp`, `rresp` = 0; beat counter = 0.
  - `awready`/`arready` follow state, so `awready` = 1 in the first cycle after `srst` falls if `awvalid` is high.
- Read latency: AR handshake in cycle N, first `rvalid` in cycle N+1. Each subsequent beat is valid in the cycle after the previous handshake.
- Write latency: the last W handshake in cycle N gives `bvalid` in cycle N+1.
- With continuous `wvalid`/`rready`, burst throughput is one beat per cycle.
- Outputs hold stable while valid is high and ready is low (AXI rule).
- A read in cycle N of a word written in cycle N−1 returns the new data (the array is write-first from the next cycle).
- `srst` mid-burst aborts it immediately: state returns to IDLE and array contents are preserved.
- Maximum burst length is 256 beats; the beat counter is 8 bits.

## Configuration
- `HOSTED_SYS_MEM_ERR_EN` defined:
  - An out-of-range beat returns SLVERR in `rresp` (`rdata` = 0) or makes `bresp` SLVERR; an out-of-range write does not touch the array.
  - A W beat whose `wlast` mismatches its position (set early or missing on the final beat) also makes `bresp` SLVERR.
  - Errors are sticky per burst.
- Not defined: addresses wrap modulo `DEPTH_WORDS`, responses are always OKAY, and `wlast` is ignored.

## Test plan
- Reset, then preload `INIT_FILE` with word 0 = 32'hDEAD_BEEF. An AR to addr 0 with `arlen`=0 returns `rdata` = 32'hDEAD_BEEF, `rlast`=1 and `rvalid` in the cycle after the AR handshake.
- An INCR write with `awlen`=3 at 0x100 of 1,2,3,4 gives `bvalid` one cycle after beat 4. An INCR read of the same region returns 1,2,3,4 on back-to-back cycles with `rlast` only on beat 4.
- Write 32'hFFFF_FFFF to 0x40, then write 32'h0000_00AA with `wstrb`=4'b0001. A read returns 32'hFFFF_FFAA.
- `awvalid` and `arvalid` are both raised for three consecutive transactions. The grant order is W, R, W, and `awready`/`arready` are never simultaneously high.
- `rready` is held low for 5 cycles mid-burst. `rdata`/`rlast` stay stable and no beat is skipped.
- With the macro defined, an AR to `BASE_ADDR` + 4·`DEPTH_WORDS` returns `rresp` = SLVERR. With the macro undefined, the same AR returns word 0.

Source files
------------

// File: rtl/hosted_sys_mem_if.sv
// AXI burst interface (32-bit data, 4-bit ID) between the hosted interconnect and system memory.
interface axib_if;
  logic        awvalid;
  logic        awready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [1:0]  awburst;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        bvalid;
  logic        bready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        arvalid;
  logic        arready;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [1:0]  arburst;
  logic        rvalid;
  logic        rready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;

  modport s (
    input  awvalid, awid, awaddr, awlen, awburst,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bid, bresp,
    input  bready,
    input  arvalid, arid, araddr, arlen, arburst,
    output arready,
    output rvalid, rid, rdata, rresp, rlast,
    input  rready
  );

  modport m (
    output awvalid, awid, awaddr, awlen, awburst,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bid, bresp,
    output bready,
    output arvalid, arid, araddr, arlen, arburst,
    input  arready,
    input  rvalid, rid, rdata, rresp, rlast,
    output rready
  );
endinterface

// File: rtl/hosted_sys_mem.sv
// Single-ported simulation system memory behind an AXI burst slave, round-robin read/write arbitration.
// Define HOSTED_SYS_MEM_ERR_EN for SLVERR on out-of-range beats and wlast mismatches.
module hosted_sys_mem #(
  parameter int unsigned DEPTH_WORDS = 65536,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter string       INIT_FILE   = ""
) (
  input logic clk,
  input logic srst,
  axib_if.s   sys_mem
);
  localparam int AW = $clog2(DEPTH_WORDS);
`ifdef HOSTED_SYS_MEM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_t;
  state_t r_state, w_state_nxt;

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdata;
  logic [29:0] r_off;
  logic [7:0]  r_len, r_beat;
  logic [1:0]  r_burst, r_bresp, r_rresp;
  logic [3:0]  r_id;
  logic        r_err, r_last_wr, r_rlast;

  logic        w_grant_wr, w_grant_rd, w_aw_hs, w_ar_hs, w_w_hs, w_r_hs, w_b_hs;
  logic        w_last_beat, w_werr, w_rerr, w_wr_en, w_rd_en;
  logic [29:0] w_aw_off, w_ar_off, w_off_nxt, w_rd_off;

  // Out-of-range only matters when error reporting is built in; otherwise the index wraps.
  function automatic logic f_oor(input logic [29:0] off);
    return ERR_EN && ((off >> AW) != 30'd0);
  endfunction

  assign w_grant_wr  = sys_mem.awvalid && (!sys_mem.arvalid || !r_last_wr);
  assign w_grant_rd  = sys_mem.arvalid && !w_grant_wr;
  assign w_aw_hs     = (r_state == IDLE) && w_grant_wr;
  assign w_ar_hs     = (r_state == IDLE) && w_grant_rd;
  assign w_w_hs      = (r_state == WDATA) && sys_mem.wvalid;
  assign w_r_hs      = (r_state == RDATA) && sys_mem.rready;
  assign w_b_hs      = (r_state == WRESP) && sys_mem.bready;
  assign w_last_beat = (r_beat == r_len);
  assign w_aw_off    = 30'((sys_mem.awaddr - BASE_ADDR) >> 2);
  assign w_ar_off    = 30'((sys_mem.araddr - BASE_ADDR) >> 2);
  assign w_off_nxt   = (r_burst == BURST_FIXED) ? r_off : r_off + 30'd1;
  assign w_rd_off    = w_ar_hs ? w_ar_off : w_off_nxt;
  assign w_werr      = r_err || f_oor(r_off) || (ERR_EN && (sys_mem.wlast != w_last_beat));
  assign w_rerr      = r_err || f_oor(w_off_nxt);
  assign w_wr_en     = w_w_hs && !f_oor(r_off) && !srst;
  assign w_rd_en     = (w_ar_hs || (w_r_hs && !w_last_beat)) && !srst;

  assign sys_mem.bid   = r_id;
  assign sys_mem.rid   = r_id;
  assign sys_mem.bresp = r_bresp;
  assign sys_mem.rresp = r_rresp;
  assign sys_mem.rdata = r_rdata;
  assign sys_mem.rlast = r_rlast;

  always_ff @(posedge clk) begin
    if (srst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt     = r_state;
    sys_mem.awready = 1'b0;
    sys_mem.arready = 1'b0;
    sys_mem.wready  = 1'b0;
    sys_mem.bvalid  = 1'b0;
    sys_mem.rvalid  = 1'b0;
    case (r_state)
      IDLE: begin
        sys_mem.awready = w_grant_wr;
        sys_mem.arready = w_grant_rd;
        if (w_grant_wr)      w_state_nxt = WDATA;
        else if (w_grant_rd) w_state_nxt = RDATA;
        else                 w_state_nxt = IDLE;
      end
      WDATA: begin
        sys_mem.wready = 1'b1;
        if (sys_mem.wvalid && w_last_beat) w_state_nxt = WRESP;
        else                               w_state_nxt = WDATA;
      end
      WRESP: begin
        sys_mem.bvalid = 1'b1;
        if (sys_mem.bready) w_state_nxt = IDLE;
        else                w_state_nxt = WRESP;
      end
      RDATA: begin
        sys_mem.rvalid = 1'b1;
        if (sys_mem.rready && w_last_beat) w_state_nxt = IDLE;
        else                               w_state_nxt = RDATA;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      r_off     <= 30'd0;
      r_len     <= 8'd0;
      r_beat    <= 8'd0;
      r_burst   <= 2'b00;
      r_id      <= 4'd0;
      r_err     <= 1'b0;
      r_last_wr <= 1'b0;
      r_rlast   <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_rresp   <= RESP_OKAY;
    end else if (w_aw_hs) begin
      r_id    <= sys_mem.awid;
      r_off   <= w_aw_off;
      r_len   <= sys_mem.awlen;
      r_burst <= sys_mem.awburst;
      r_beat  <= 8'd0;
      r_err   <= 1'b0;
    end else if (w_ar_hs) begin
      r_id    <= sys_mem.arid;
      r_off   <= w_ar_off;
      r_len   <= sys_mem.arlen;
      r_burst <= sys_mem.arburst;
      r_beat  <= 8'd0;
      r_err   <= f_oor(w_ar_off);
      r_rresp <= f_oor(w_ar_off) ? RESP_SLVERR : RESP_OKAY;
      r_rlast <= (sys_mem.arlen == 8'd0);
    end else if (w_w_hs) begin
      r_off  <= w_off_nxt;
      r_beat <= r_beat + 8'd1;
      r_err  <= w_werr;
      if (w_last_beat) r_bresp <= w_werr ? RESP_SLVERR : RESP_OKAY;
    end else if (w_r_hs) begin
      // rlast/rresp describe the beat fetched here, i.e. the one presented next cycle.
      r_off   <= w_off_nxt;
      r_beat  <= r_beat + 8'd1;
      r_err   <= w_rerr;
      r_rresp <= w_rerr ? RESP_SLVERR : RESP_OKAY;
      r_rlast <= ((r_beat + 8'd1) == r_len) && !w_last_beat;
      if (w_last_beat) r_last_wr <= 1'b0;
    end else if (w_b_hs) begin
      r_last_wr <= 1'b1;
    end
  end

  // Array contents survive srst; only the access machine is reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (sys_mem.wstrb[b]) r_mem[r_off[AW-1:0]][8*b +: 8] <= sys_mem.wdata[8*b +: 8];
      end
    end
    if (w_rd_en) r_rdata <= f_oor(w_rd_off) ? 32'd0 : r_mem[w_rd_off[AW-1:0]];
  end
endmodule

// File: tb/tb_hosted_sys_mem.sv
// Scoreboard bench for hosted_sys_mem: drivers push expected R/B responses, a negedge monitor checks them.
module tb_hosted_sys_mem;
  logic clk = 1'b0;
  logic srst;
  always #5 clk = ~clk;

  axib_if bus();

  hosted_sys_mem #(
    .DEPTH_WORDS(1024),
    .BASE_ADDR  (32'h0000_0000),
    .INIT_FILE  ("")
  ) dut (
    .clk    (clk),
    .srst   (srst),
    .sys_mem(bus)
  );

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [1:0]  resp;
    logic [3:0]  id;
  } rexp_t;
  typedef struct {
    logic [1:0] resp;
    logic [3:0] id;
  } bexp_t;

  rexp_t       rq[$];
  bexp_t       bq[$];
  int          r_hs_cyc[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  bit          both_seen = 1'b0;
  logic [31:0] wd [0:7];
  logic [3:0]  ws [0:7];
  logic [7:0]  grants [0:2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: compares every R/B handshake against the scoreboard and checks R stability under stall.
  initial begin
    logic [31:0] prev_d;
    logic        prev_l;
    bit          have_prev;
    rexp_t       re;
    bexp_t       be;
    have_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.awready && bus.arready) both_seen = 1'b1;
      if (!srst && bus.rvalid && bus.rready) begin
        r_hs_cyc.push_back(cyc);
        if (rq.size() == 0) check("r_unexpected", 32'd1, 32'd0);
        else begin
          re = rq.pop_front();
          check("rdata", bus.rdata, re.data);
          check("rlast", {31'd0, bus.rlast}, {31'd0, re.last});
          check("rresp", {30'd0, bus.rresp}, {30'd0, re.resp});
          check("rid", {28'd0, bus.rid}, {28'd0, re.id});
        end
        have_prev = 1'b0;
      end else if (!srst && bus.rvalid) begin
        if (have_prev) begin
          check("r_hold_data", bus.rdata, prev_d);
          check("r_hold_last", {31'd0, bus.rlast}, {31'd0, prev_l});
        end
        prev_d    = bus.rdata;
        prev_l    = bus.rlast;
        have_prev = 1'b1;
      end else begin
        have_prev = 1'b0;
      end
      if (!srst && bus.bvalid && bus.bready) begin
        if (bq.size() == 0) check("b_unexpected", 32'd1, 32'd0);
        else begin
          be = bq.pop_front();
          check("bresp", {30'd0, bus.bresp}, {30'd0, be.resp});
          check("bid", {28'd0, bus.bid}, {28'd0, be.id});
        end
      end
    end
  end

  task automatic push_r(input logic [31:0] d, input logic l, input logic [1:0] rs, input logic [3:0] id);
    rq.push_back('{data: d, last: l, resp: rs, id: id});
  endtask

  task automatic send_aw(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id,
                         output int waited);
    int t;
    bus.awaddr = addr; bus.awlen = len; bus.awburst = 2'b01; bus.awid = id; bus.awvalid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!bus.awready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!bus.awready) check("aw_timeout", 32'd0, 32'd1);
    waited = t;
    @(posedge clk);
    #1 bus.awvalid = 1'b0;
  endtask

  task automatic send_w(input int len, input logic [3:0] id);
    int t;
    bq.push_back('{resp: 2'b00, id: id});
    for (int i = 0; i <= len; i++) begin
      bus.wvalid = 1'b1; bus.wdata = wd[i]; bus.wstrb = ws[i]; bus.wlast = (i == len);
      t = 0;
      @(negedge clk);
      while (!bus.wready && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (!bus.wready) check("w_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    @(negedge clk);
    check("b_latency", {31'd0, bus.bvalid}, 32'd1);
  endtask

  task automatic send_ar(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id);
    int t;
    bus.araddr = addr; bus.arlen = len; bus.arburst = 2'b01; bus.arid = id; bus.arvalid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!bus.arready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!bus.arready) check("ar_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 bus.arvalid = 1'b0;
    @(negedge clk);
    check("r_latency", {31'd0, bus.rvalid}, 32'd1);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((rq.size() != 0 || bq.size() != 0) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (rq.size() != 0 || bq.size() != 0) check("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic write1(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] s,
                        input logic [3:0] id);
    int w;
    wd[0] = d; ws[0] = s;
    send_aw(addr, 8'd0, id, w);
    send_w(0, id);
    wait_drain();
  endtask

  initial begin
    int w;
    int t;
    srst = 1'b1;
    bus.awvalid = 1'b0; bus.awid = 4'd0; bus.awaddr = 32'd0; bus.awlen = 8'd0; bus.awburst = 2'b01;
    bus.wvalid = 1'b0; bus.wdata = 32'd0; bus.wstrb = 4'd0; bus.wlast = 1'b0; bus.bready = 1'b1;
    bus.arvalid = 1'b0; bus.arid = 4'd0; bus.araddr = 32'd0; bus.arlen = 8'd0; bus.arburst = 2'b01;
    bus.rready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_bvalid", {31'd0, bus.bvalid}, 32'd0);
    check("rst_rvalid", {31'd0, bus.rvalid}, 32'd0);
    check("rst_wready", {31'd0, bus.wready}, 32'd0);
    check("rst_rlast",  {31'd0, bus.rlast}, 32'd0);
    check("rst_bresp",  {30'd0, bus.bresp}, 32'd0);
    check("rst_rresp",  {30'd0, bus.rresp}, 32'd0);

    // First write right after reset release: awready must be immediate.
    @(posedge clk);
    #1 srst = 1'b0;
    wd[0] = 32'hDEAD_BEEF; ws[0] = 4'hF;
    send_aw(32'h0, 8'd0, 4'd3, w);
    check("awready_after_rst", w, 32'd0);
    send_w(0, 4'd3);
    wait_drain();
    push_r(32'hDEAD_BEEF, 1'b1, 2'b00, 4'd4);
    send_ar(32'h0, 8'd0, 4'd4);
    wait_drain();

    // INCR burst write and back-to-back burst read.
    for (int i = 0; i < 4; i++) begin
      wd[i] = 32'(i + 1);
      ws[i] = 4'hF;
    end
    send_aw(32'h100, 8'd3, 4'd5, w);
    send_w(3, 4'd5);
    wait_drain();
    r_hs_cyc.delete();
    for (int i = 0; i < 4; i++) push_r(32'(i + 1), (i == 3), 2'b00, 4'd6);
    send_ar(32'h100, 8'd3, 4'd6);
    wait_drain();
    check("r_b2b_span", 32'(r_hs_cyc[3] - r_hs_cyc[0]), 32'd3);

    // Byte strobe merge.
    write1(32'h40, 32'hFFFF_FFFF, 4'hF, 4'd7);
    write1(32'h40, 32'h0000_00AA, 4'b0001, 4'd8);
    push_r(32'hFFFF_FFAA, 1'b1, 2'b00, 4'd9);
    send_ar(32'h40, 8'd0, 4'd9);
    wait_drain();

    // rready stall mid-burst.
    for (int i = 0; i < 4; i++) push_r(32'(i + 1), (i == 3), 2'b00, 4'd10);
    send_ar(32'h100, 8'd3, 4'd10);
    t = 0;
    while (rq.size() > 3 && t < 50) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    #1 bus.rready = 1'b0;
    repeat (5) @(posedge clk);
    #1 bus.rready = 1'b1;
    wait_drain();

    // Arbitration after reset with both requests pending: W, R, W.
    @(posedge clk);
    #1 srst = 1'b1;
    @(posedge clk);
    #1 srst = 1'b0;
    wd[0] = 32'h0000_0011; ws[0] = 4'hF;
    for (int k = 0; k < 3; k++) begin
      bus.awaddr = 32'h200; bus.awlen = 8'd0; bus.awburst = 2'b01; bus.awid = 4'd1; bus.awvalid = 1'b1;
      bus.araddr = 32'h100; bus.arlen = 8'd0; bus.arburst = 2'b01; bus.arid = 4'd2; bus.arvalid = 1'b1;
      t = 0;
      @(negedge clk);
      while (!bus.awready && !bus.arready && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (bus.awready) begin
        grants[k] = "W";
        @(posedge clk);
        #1 bus.awvalid = 1'b0;
        send_w(0, 4'd1);
      end else begin
        grants[k] = "R";
        push_r(32'd1, 1'b1, 2'b00, 4'd2);
        @(posedge clk);
        #1 bus.arvalid = 1'b0;
      end
      wait_drain();
    end
    bus.awvalid = 1'b0; bus.arvalid = 1'b0;
    check("grant0", {24'd0, grants[0]}, {24'd0, 8'h57});
    check("grant1", {24'd0, grants[1]}, {24'd0, 8'h52});
    check("grant2", {24'd0, grants[2]}, {24'd0, 8'h57});

    // Address one past the top of the array.
`ifdef HOSTED_SYS_MEM_ERR_EN
    push_r(32'h0, 1'b1, 2'b10, 4'd11);
`else
    push_r(32'hDEAD_BEEF, 1'b1, 2'b00, 4'd11);
`endif
    send_ar(32'h0000_1000, 8'd0, 4'd11);
    wait_drain();

    repeat (3) @(posedge clk);
    check("aw_ar_exclusive", {31'd0, both_seen}, 32'd0);
    check("queues_empty", 32'(rq.size() + bq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
